// File: rtl/usb_ep_out_parser.sv
// OUT-endpoint frame parser: A5/CMD/LEN/payload/CSUM, one FIFO read per 2 cycles, LED frames applied 2 cycles after CSUM read.
// Held frames stall FIFO reads until frm_ack; optional mid-frame idle abort under USB_EP_OUT_TIMEOUT_EN.
module usb_ep_out_parser #(
  parameter int MAX_LEN        = 8,
  parameter int TIMEOUT_CYCLES = 48000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] ep_dout,
  input  logic       ep_empty,
  output logic       ep_re,
  output logic [7:0] led_o,
  output logic       frm_valid,
  output logic [7:0] frm_cmd,
  output logic [3:0] frm_len,
  input  logic       frm_ack,
  input  logic [3:0] pl_addr,
  output logic [7:0] pl_data,
  output logic [7:0] err_cnt
);

  typedef enum logic [2:0] {S_SYNC, S_CMD, S_LEN, S_DATA, S_CSUM, S_HOLD} state_t;

  state_t     state_q, state_d;
  logic       pend_q, pend_d;
  logic       gap_q, gap_d;
  logic [7:0] cmd_q, cmd_d;
  logic [3:0] len_q, len_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] sum_q, sum_d;
  logic [7:0] led_q, led_d;
  logic       vld_q, vld_d;
  logic [7:0] fcmd_q, fcmd_d;
  logic [3:0] flen_q, flen_d;
  logic [7:0] err_q, err_d;
  logic [7:0] pl_q [16];
  logic       pl_we;
  logic       err_inc;
  logic       to_hit;
  logic [7:0] sum_nxt;

  // gap_q suppresses the read strobe for one cycle after reset and after a frame release
  assign ep_re     = rst_i && !ep_empty && !pend_q && !gap_q && (state_q != S_HOLD);
  assign led_o     = led_q;
  assign frm_valid = vld_q;
  assign frm_cmd   = fcmd_q;
  assign frm_len   = flen_q;
  assign err_cnt   = err_q;
  assign pl_data   = (pl_addr < 4'(MAX_LEN)) ? pl_q[pl_addr] : 8'h00;
  assign sum_nxt   = sum_q + ep_dout;

`ifdef USB_EP_OUT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = '0;
    to_hit = 1'b0;
    if (!pend_q && (state_q inside {S_CMD, S_LEN, S_DATA, S_CSUM})) begin
      if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) to_hit = 1'b1;
      else cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pend_d  = ep_re;
    gap_d   = 1'b0;
    cmd_d   = cmd_q;
    len_d   = len_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    led_d   = led_q;
    vld_d   = vld_q;
    fcmd_d  = fcmd_q;
    flen_d  = flen_q;
    pl_we   = 1'b0;
    err_inc = 1'b0;
    if (pend_q) begin
      case (state_q)
        S_SYNC: if (ep_dout == 8'hA5) state_d = S_CMD;
        S_CMD: begin
          cmd_d   = ep_dout;
          sum_d   = ep_dout;
          state_d = S_LEN;
        end
        S_LEN: begin
          len_d = ep_dout[3:0];
          sum_d = sum_nxt;
          idx_d = 4'd0;
          if (ep_dout > 8'(MAX_LEN)) begin
            err_inc = 1'b1;
            state_d = S_SYNC;
          end else if (ep_dout == 8'h00) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          pl_we = 1'b1;
          idx_d = idx_q + 4'd1;
          sum_d = sum_nxt;
          if (idx_q == len_q - 4'd1) state_d = S_CSUM;
        end
        S_CSUM: begin
          state_d = S_SYNC;
          if (sum_nxt != 8'h00) begin
            err_inc = 1'b1;
          end else if (cmd_q == 8'h01 && len_q == 4'd1) begin
            led_d = pl_q[0];
          end else begin
            vld_d   = 1'b1;
            fcmd_d  = cmd_q;
            flen_d  = len_q;
            state_d = S_HOLD;
          end
        end
        default: ;
      endcase
    end
    if (state_q == S_HOLD && frm_ack) begin
      vld_d   = 1'b0;
      gap_d   = 1'b1;
      state_d = S_SYNC;
    end
    if (to_hit) begin
      err_inc = 1'b1;
      state_d = S_SYNC;
    end
    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_SYNC;
      pend_q  <= 1'b0;
      gap_q   <= 1'b1;
      cmd_q   <= 8'h00;
      len_q   <= 4'd0;
      idx_q   <= 4'd0;
      sum_q   <= 8'h00;
      led_q   <= 8'h0F;
      vld_q   <= 1'b0;
      fcmd_q  <= 8'h00;
      flen_q  <= 4'd0;
      err_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      gap_q   <= gap_d;
      cmd_q   <= cmd_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      led_q   <= led_d;
      vld_q   <= vld_d;
      fcmd_q  <= fcmd_d;
      flen_q  <= flen_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (pl_we) pl_q[idx_q] <= ep_dout;
  end

endmodule

// File: tb/tb_usb_ep_out_parser.sv
// Directed bench for usb_ep_out_parser with a small behavioural OUT FIFO model.
module tb_usb_ep_out_parser;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ep_dout = 8'h00;
  logic       ep_empty;
  logic       ep_re;
  logic [7:0] led_o;
  logic       frm_valid;
  logic [7:0] frm_cmd;
  logic [3:0] frm_len;
  logic       frm_ack;
  logic [3:0] pl_addr;
  logic [7:0] pl_data;
  logic [7:0] err_cnt;

  int errors = 0;
  int checks = 0;

  logic [7:0] fifo_mem [1024];
  int wr_ptr = 0;
  int rd_ptr = 0;

  always #5 clk = ~clk;

  assign ep_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (ep_re) begin
      ep_dout <= fifo_mem[rd_ptr[9:0]];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  usb_ep_out_parser #(.MAX_LEN(8), .TIMEOUT_CYCLES(100)) dut (
    .clk_i(clk), .rst_i(rst_n), .ep_dout(ep_dout), .ep_empty(ep_empty), .ep_re(ep_re),
    .led_o(led_o), .frm_valid(frm_valid), .frm_cmd(frm_cmd), .frm_len(frm_len),
    .frm_ack(frm_ack), .pl_addr(pl_addr), .pl_data(pl_data), .err_cnt(err_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr[9:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  // Returns in the cycle where the target-th read's byte is on ep_dout.
  task automatic wait_rd(input int target, input string nm);
    int n;
    n = 0;
    while (rd_ptr < target && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (rd_ptr < target) begin
      errors++;
      $display("FAIL %s_reads: got %0d reads want %0d", nm, rd_ptr, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; frm_ack = 1'b0; pl_addr = 4'd0;
    repeat (3) tick();
    checks++; if (ep_re !== 1'b0) begin errors++; $display("FAIL reset_ep_re: got %b want 0", ep_re); end
    checks++; if (led_o !== 8'h0F) begin errors++; $display("FAIL reset_led: got %h want 0f", led_o); end
    checks++; if (frm_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", frm_valid); end
    checks++; if (frm_cmd !== 8'h00) begin errors++; $display("FAIL reset_cmd: got %h want 00", frm_cmd); end
    checks++; if (frm_len !== 4'h0) begin errors++; $display("FAIL reset_len: got %h want 0", frm_len); end
    checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL reset_err: got %h want 00", err_cnt); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_resync_badcsum();
    int base;
    base = wr_ptr;
    push(8'h00); push(8'hFF); push(8'hA5); push(8'h01); push(8'h01); push(8'h3C); push(8'h00);
    wait_rd(base + 7, "resync");
    tick(); tick();
    checks++; if (led_o !== 8'h0F) begin errors++; $display("FAIL badcsum_led: got %h want 0f", led_o); end
    checks++; if (err_cnt !== 8'h01) begin errors++; $display("FAIL badcsum_err: got %h want 01", err_cnt); end
    checks++; if (frm_valid !== 1'b0) begin errors++; $display("FAIL badcsum_valid: got %b want 0", frm_valid); end
  endtask

  task automatic test_led();
    int base;
    base = wr_ptr;
    push(8'hA5); push(8'h01); push(8'h01); push(8'h3C); push(8'hC2);
    wait_rd(base + 5, "led");
    checks++; if (led_o !== 8'h0F) begin errors++; $display("FAIL led_early: got %h want 0f", led_o); end
    tick();
    checks++; if (led_o !== 8'h3C) begin errors++; $display("FAIL led_update: got %h want 3c", led_o); end
    checks++; if (err_cnt !== 8'h01) begin errors++; $display("FAIL led_err: got %h want 01", err_cnt); end
    checks++; if (frm_valid !== 1'b0) begin errors++; $display("FAIL led_valid: got %b want 0", frm_valid); end
  endtask

  task automatic test_hold();
    int base;
    int re_seen;
    base = wr_ptr;
    push(8'hA5); push(8'h10); push(8'h02); push(8'h11); push(8'h22); push(8'hBB);
    push(8'h00); push(8'h00);
    wait_rd(base + 6, "hold");
    tick();
    checks++; if (frm_valid !== 1'b1) begin errors++; $display("FAIL hold_valid: got %b want 1", frm_valid); end
    checks++; if (frm_cmd !== 8'h10) begin errors++; $display("FAIL hold_cmd: got %h want 10", frm_cmd); end
    checks++; if (frm_len !== 4'd2) begin errors++; $display("FAIL hold_len: got %0d want 2", frm_len); end
    pl_addr = 4'd0; #1;
    checks++; if (pl_data !== 8'h11) begin errors++; $display("FAIL hold_pl0: got %h want 11", pl_data); end
    pl_addr = 4'd1; #1;
    checks++; if (pl_data !== 8'h22) begin errors++; $display("FAIL hold_pl1: got %h want 22", pl_data); end
    pl_addr = 4'd9; #1;
    checks++; if (pl_data !== 8'h00) begin errors++; $display("FAIL hold_pl_oob: got %h want 00", pl_data); end
    pl_addr = 4'd0;
    re_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (ep_re !== 1'b0) re_seen++;
      tick();
    end
    checks++; if (re_seen != 0) begin errors++; $display("FAIL hold_stall: got %0d strobes want 0", re_seen); end
    checks++; if (rd_ptr != base + 6) begin errors++; $display("FAIL hold_rdptr: got %0d want %0d", rd_ptr, base + 6); end
    checks++; if (frm_valid !== 1'b1) begin errors++; $display("FAIL hold_keep: got %b want 1", frm_valid); end
    frm_ack = 1'b1;
    tick();
    frm_ack = 1'b0;
    checks++; if (frm_valid !== 1'b0) begin errors++; $display("FAIL ack_valid: got %b want 0", frm_valid); end
    checks++; if (ep_re !== 1'b0) begin errors++; $display("FAIL ack_gap: got %b want 0", ep_re); end
    tick();
    checks++; if (ep_re !== 1'b1) begin errors++; $display("FAIL ack_resume: got %b want 1", ep_re); end
    wait_rd(base + 8, "resume");
    tick(); tick();
    checks++; if (frm_valid !== 1'b0) begin errors++; $display("FAIL after_ack_valid: got %b want 0", frm_valid); end
  endtask

  task automatic test_oversize();
    int base;
    base = wr_ptr;
    push(8'hA5); push(8'h20); push(8'h09); push(8'h01); push(8'h02);
    push(8'hA5); push(8'h01); push(8'h01); push(8'h77); push(8'h87);
    wait_rd(base + 10, "oversize");
    tick(); tick();
    checks++; if (err_cnt !== 8'h02) begin errors++; $display("FAIL oversize_err: got %h want 02", err_cnt); end
    checks++; if (led_o !== 8'h77) begin errors++; $display("FAIL oversize_led: got %h want 77", led_o); end
    checks++; if (frm_valid !== 1'b0) begin errors++; $display("FAIL oversize_valid: got %b want 0", frm_valid); end
  endtask

  task automatic test_timeout();
    int base;
    base = wr_ptr;
    push(8'hA5); push(8'h01);
    wait_rd(base + 2, "timeout_hdr");
    repeat (95) tick();
    checks++; if (err_cnt !== 8'h02) begin errors++; $display("FAIL timeout_early: got %h want 02", err_cnt); end
    repeat (10) tick();
`ifdef USB_EP_OUT_TIMEOUT_EN
    checks++; if (err_cnt !== 8'h03) begin errors++; $display("FAIL timeout_err: got %h want 03", err_cnt); end
    base = wr_ptr;
    push(8'hA5); push(8'h01); push(8'h01); push(8'h55); push(8'hA9);
    wait_rd(base + 5, "timeout_frame");
`else
    checks++; if (err_cnt !== 8'h02) begin errors++; $display("FAIL timeout_err: got %h want 02", err_cnt); end
    base = wr_ptr;
    push(8'h01); push(8'h55); push(8'hA9);
    wait_rd(base + 3, "timeout_frame");
`endif
    tick(); tick();
    checks++; if (led_o !== 8'h55) begin errors++; $display("FAIL timeout_led: got %h want 55", led_o); end
  endtask

  task automatic test_reset_mid();
    int base;
    base = wr_ptr;
    push(8'hA5); push(8'h30); push(8'h04); push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h22);
    push(8'hA5); push(8'h01); push(8'h01); push(8'h5A); push(8'hA4);
    wait_rd(base + 5, "reset_mid");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (ep_re !== 1'b0) begin errors++; $display("FAIL rmid_ep_re: got %b want 0", ep_re); end
    checks++; if (led_o !== 8'h0F) begin errors++; $display("FAIL rmid_led: got %h want 0f", led_o); end
    checks++; if (frm_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", frm_valid); end
    checks++; if (frm_cmd !== 8'h00) begin errors++; $display("FAIL rmid_cmd: got %h want 00", frm_cmd); end
    checks++; if (frm_len !== 4'h0) begin errors++; $display("FAIL rmid_len: got %h want 0", frm_len); end
    checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL rmid_err: got %h want 00", err_cnt); end
    wait_rd(base + 13, "reset_follow");
    tick(); tick();
    checks++; if (led_o !== 8'h5A) begin errors++; $display("FAIL rmid_follow_led: got %h want 5a", led_o); end
    checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL rmid_follow_err: got %h want 00", err_cnt); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_resync_badcsum();
    test_led();
    test_hold();
    test_oversize();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
